pn_lfsr_stream_gen: RTL
=======================

Name: pn_lfsr_stream_gen

Overview:
Parametrised Fibonacci LFSR PN-sequence generator with an AXI-Stream-style output.
- A seed and tap polynomial are loaded per run through a valid/ready handshake.
- Emits OUT_W PN bits per beat for a programmable number of beats, or free-running.
- Honours downstream backpressure, supports abort, and rejects lock-up configurations.
- Sits between the control/config side and the scrambler/modulator datapath.

Parameters:
LFSR_W, 7, LFSR register width (2..32).
OUT_W, 1, PN bits emitted per output beat (1..LFSR_W).
LEN_W, 16, width of the beat-count field.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
seed_valid  in  1  seed/poly/seq_len offered
seed_ready  out  1  block idle, can accept a configuration
seed_data  in  LFSR_W  initial LFSR state
poly  in  LFSR_W  tap mask; bit i set = s[i] participates in feedback
seq_len  in  LEN_W  beats to emit; 0 = free-running until abort
abort  in  1  terminate the current run
m_tvalid  out  1  output beat valid
m_tready  in  1  downstream ready
m_tdata  out  OUT_W  PN bits; bit 0 = earliest generated
m_tlast  out  1  final beat of a finite run
busy  out  1  high while in RUN
cfg_err  out  1  one-cycle pulse: seed or poly rejected

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (port reset). Reset forces IDLE, LFSR = 0, beat counter = 0, and m_tvalid = m_tlast = busy = cfg_err = 0. seed_ready = 1 from the first cycle after reset deasserts.
- LFSR step (single bit):
  - out = s[0]
  - fb = ^(s & poly)
  - s_next = {fb, s[LFSR_W-1:1]}
  - One beat applies OUT_W steps; m_tdata[k] = output of step k.
- States are IDLE and RUN.
- IDLE:
  - seed_ready = 1.
  - On seed_valid && seed_ready with seed_data == 0 or poly == 0: cfg_err pulses the next cycle and the state stays IDLE.
  - Otherwise capture poly and seq_len, and go to RUN.
  - The first beat is computed from seed_data and registered, so m_tvalid = 1 in the cycle after acceptance (latency 1).
  - The LFSR holds the state after OUT_W steps.
- RUN:
  - seed_ready = 0, busy = 1.
  - m_tdata and m_tlast stay stable while m_tvalid && !m_tready.
  - On handshake (m_tvalid && m_tready), the beat counter increments and the next beat is registered the same edge. Sustained throughput is 1 beat/cycle with no bubbles.
  - m_tlast = 1 on beat index seq_len-1. It is never asserted when seq_len == 0.
- RUN exit:
  - On the handshake of the m_tlast beat, go to IDLE with m_tvalid = 0 the next cycle.
  - seed_ready rises that next cycle. No overlap with the final beat.
- Free-running (seq_len == 0): the beat counter wraps at 2^LEN_W silently, with no effect on output.
- abort:
  - In RUN, go to IDLE the next cycle and drop m_tvalid, even mid-backpressure. The pending beat is discarded and no m_tlast is produced.
  - In IDLE, abort is ignored.
  - abort in the same cycle as the last-beat handshake gives the same result as a normal finish.
- seed_valid during RUN is ignored (seed_ready = 0).
- Reset mid-run has the same effect as power-on reset; any beat in flight is lost.
- Period is 2^LFSR_W-1 bits when poly is primitive; the block does not check primitivity.

Decomposition:
- Shared package pn_gen_pkg:
  - state enum {IDLE, RUN}
  - default tap constants per width (e.g. 3'b011, 7'b0000011)
  - a function lfsr_step(s, poly) returning {s_next, out}
- Sub-module pn_lfsr_step_n: combinational OUT_W-step unroll (inputs state and poly; outputs next state and OUT_W bits), instantiated once in the top.

Test Plan:
1. LFSR_W=3, OUT_W=1, poly=3'b011, seed=3'b001, seq_len=8, m_tready=1 -> m_tdata = 1,0,0,1,0,1,1,1 on consecutive cycles; m_tlast only on the 8th; seed_ready returns 1 the cycle after.
2. Same config with OUT_W=4, seq_len=3 -> beats 4'b1001, 4'b1110, 4'b0100; first m_tvalid 1 cycle after seed acceptance.
3. Backpressure: scenario 1 with m_tready low for 10 cycles after beat 4 -> beat 5 (value 0) held stable for all 10 cycles; full sequence unchanged; no beats lost or duplicated.
4. Configuration rejection: seed=0 or poly=0 -> cfg_err pulses one cycle, busy stays 0, m_tvalid stays 0, seed_ready stays 1.
5. Free-running: seq_len=0 for 20 beats, then abort while m_tready=0 -> output repeats with period 7; m_tlast never asserted; m_tvalid=0 and busy=0 the cycle after abort.
6. Reset mid-run and seed during RUN: reset asserted at beat 3 -> all outputs 0 the next cycle and seed_ready=1 after deassertion; a seed offered during RUN is not accepted (seed_ready=0) and has no effect on the stream.

Source files
------------

// File: rtl/pn_lfsr_stream_gen_pkg.sv
// Shared definitions for the PN LFSR stream generator.
// Provides the controller state type, reference tap masks for common widths
// and a single-step Fibonacci LFSR helper (operates on up to 32-bit state).
package pn_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned LFSR_MAX_W = 32;

  // Default (primitive) tap masks; bit i set = s[i] feeds the XOR.
  localparam logic [2:0] TAP_W3 = 3'b011;
  localparam logic [3:0] TAP_W4 = 4'b0011;
  localparam logic [4:0] TAP_W5 = 5'b00101;
  localparam logic [6:0] TAP_W7 = 7'b0000011;

  typedef struct packed {
    logic [LFSR_MAX_W-1:0] s_next;
    logic                  out;
  } step_t;

  // One LFSR step for a register of width w (bits above w-1 must be zero).
  function automatic step_t lfsr_step(input logic [LFSR_MAX_W-1:0] s,
                                      input logic [LFSR_MAX_W-1:0] poly,
                                      input int unsigned           w);
    step_t r;
    r.out         = s[0];
    r.s_next      = s >> 1;
    r.s_next[w-1] = ^(s & poly);
    return r;
  endfunction

endpackage

// File: rtl/pn_lfsr_step_n.sv
// Combinational OUT_W-step unroll of a Fibonacci LFSR.
// Ports:
//   state      current LFSR state
//   poly       tap mask
//   state_next state after OUT_W steps
//   bits       generated bits, bit 0 = first step's output
module pn_lfsr_step_n
  import pn_gen_pkg::*;
#(
  parameter int unsigned LFSR_W = 7,
  parameter int unsigned OUT_W  = 1
) (
  input  logic [LFSR_W-1:0] state,
  input  logic [LFSR_W-1:0] poly,
  output logic [LFSR_W-1:0] state_next,
  output logic [OUT_W-1:0]  bits
);

  logic [LFSR_W-1:0] s_work;

  always_comb begin
    s_work = state;
    bits   = '0;
    for (int unsigned k = 0; k < OUT_W; k++) begin
      bits[k] = s_work[0];
      s_work  = {^(s_work & poly), s_work[LFSR_W-1:1]};
    end
    state_next = s_work;
  end

endmodule

// File: rtl/pn_lfsr_stream_gen.sv
// PN-sequence generator: Fibonacci LFSR with a stream-style output.
// A seed/poly/length configuration is accepted in IDLE; the block then emits
// OUT_W PN bits per beat for seq_len beats (or until abort when seq_len = 0).
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   seed_valid/seed_ready      configuration handshake
//   seed_data, poly, seq_len   initial state, tap mask, beat count (0 = free run)
//   abort                      terminate the current run
//   m_tvalid/m_tready          output beat handshake
//   m_tdata, m_tlast           PN bits (bit 0 earliest), last beat flag
//   busy                       high while running
//   cfg_err                    one-cycle pulse on rejected seed/poly
module pn_lfsr_stream_gen
  import pn_gen_pkg::*;
#(
  parameter int unsigned LFSR_W = 7,
  parameter int unsigned OUT_W  = 1,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seed_valid,
  output logic              seed_ready,
  input  logic [LFSR_W-1:0] seed_data,
  input  logic [LFSR_W-1:0] poly,
  input  logic [LEN_W-1:0]  seq_len,
  input  logic              abort,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [OUT_W-1:0]  m_tdata,
  output logic              m_tlast,
  output logic              busy,
  output logic              cfg_err
);

  state_t            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [LFSR_W-1:0] poly_q, poly_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  cnt_inc;
  logic [OUT_W-1:0]  tdata_q, tdata_d;
  logic              tlast_q, tlast_d;
  logic              cfg_err_q, cfg_err_d;

  logic [LFSR_W-1:0] step_in, step_poly, step_next;
  logic [OUT_W-1:0]  step_bits;
  logic              handshake;

  // One shared unroll: seeds the first beat in IDLE, advances the stream in RUN.
  assign step_in   = (state_q == IDLE) ? seed_data : lfsr_q;
  assign step_poly = (state_q == IDLE) ? poly      : poly_q;

  pn_lfsr_step_n #(
    .LFSR_W (LFSR_W),
    .OUT_W  (OUT_W)
  ) u_step (
    .state      (step_in),
    .poly       (step_poly),
    .state_next (step_next),
    .bits       (step_bits)
  );

  assign m_tvalid   = (state_q == RUN);
  assign busy       = (state_q == RUN);
  assign seed_ready = (state_q == IDLE);
  assign m_tdata    = tdata_q;
  assign m_tlast    = tlast_q;
  assign cfg_err    = cfg_err_q;

  assign handshake = m_tvalid && m_tready;
  assign cnt_inc   = cnt_q + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lfsr_q    <= '0;
      poly_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      tdata_q   <= '0;
      tlast_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      poly_q    <= poly_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      tdata_q   <= tdata_d;
      tlast_q   <= tlast_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    poly_d    = poly_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    tdata_d   = tdata_q;
    tlast_d   = tlast_q;
    cfg_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (seed_valid) begin
          if ((seed_data == '0) || (poly == '0)) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d = RUN;
            lfsr_d  = step_next;
            tdata_d = step_bits;
            poly_d  = poly;
            len_d   = seq_len;
            cnt_d   = '0;
            tlast_d = (seq_len == LEN_W'(1));
          end
        end
      end

      RUN: begin
        if ((handshake && tlast_q) || abort) begin
          state_d = IDLE;
          tlast_d = 1'b0;
        end else if (handshake) begin
          // cnt_q indexes the beat being presented; the next beat is cnt_q+1.
          // Counter wraps silently in free-running mode.
          cnt_d   = cnt_inc;
          lfsr_d  = step_next;
          tdata_d = step_bits;
          tlast_d = (len_q != '0) && (cnt_inc == (len_q - LEN_W'(1)));
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
